// File: rtl/retime_debounce_edge_pkg.sv
// rtl/retime_debounce_edge_pkg.sv - shared constants, types and helpers for the debounce block
package retime_debounce_edge_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 8;
    localparam int unsigned DEBOUNCE_MIN    = 1;
    localparam int unsigned DEBOUNCE_MAX    = 65535;

    typedef enum logic [1:0] {
        CNT_CLEAR  = 2'd0,
        CNT_INC    = 2'd1,
        CNT_ACCEPT = 2'd2
    } cnt_action_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter must hold 0..Debounce_Count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned debounce_count);
        int unsigned w;
        w = clog2(debounce_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/retime_debounce_channel.sv
// rtl/retime_debounce_channel.sv - one channel: synchroniser, debounce counter, edge pulses, sticky flag
module retime_debounce_channel
    import retime_debounce_edge_pkg::*;
#(
    parameter int unsigned Sync_Stages    = 2,
    parameter int unsigned Debounce_Count = 4
) (
    input  logic clk,
    input  logic sres,
    input  logic async_in,
    input  logic event_clr,
    output logic sync_out,
    output logic filt_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic trans_pulse,
    output logic event_sticky
);

    localparam int unsigned     CntW    = cnt_width(Debounce_Count);
    localparam logic [CntW-1:0] CntLast = CntW'(Debounce_Count - 1);

    logic [Sync_Stages-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic [CntW-1:0]        cnt_next;
    logic                   filt_q;
    logic                   filt_next;
    logic                   filt_delay_q;
    logic                   sticky_q;
    logic                   sticky_next;
    cnt_action_e            action;

    always_ff @(posedge clk) begin
        if (sres) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Sync_Stages-2:0], async_in};
        end
    end

    assign sync_out = sync_q[Sync_Stages-1];

    // Accepting on the last count step and clearing at the same edge keeps the counter from wrapping.
    always_comb begin
        action = CNT_CLEAR;
        if (sync_out != filt_q) begin
            action = (cnt_q == CntLast) ? CNT_ACCEPT : CNT_INC;
        end
    end

    always_comb begin
        cnt_next  = '0;
        filt_next = filt_q;
        unique case (action)
            CNT_INC:    cnt_next  = cnt_q + CntW'(1);
            CNT_ACCEPT: filt_next = sync_out;
            default:    ;
        endcase
    end

    assign rise_pulse  = filt_q & ~filt_delay_q;
    assign fall_pulse  = ~filt_q & filt_delay_q;
    assign trans_pulse = rise_pulse | fall_pulse;

    // A transition in the same cycle as a clear keeps the flag set.
    assign sticky_next = trans_pulse | (sticky_q & ~event_clr);

    always_ff @(posedge clk) begin
        if (sres) begin
            cnt_q        <= '0;
            filt_q       <= 1'b0;
            filt_delay_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_next;
            filt_q       <= filt_next;
            filt_delay_q <= filt_q;
            sticky_q     <= sticky_next;
        end
    end

    assign filt_out     = filt_q;
    assign event_sticky = sticky_q;

endmodule

// File: rtl/retime_debounce_edge.sv
// rtl/retime_debounce_edge.sv - multi-channel retime, debounce and edge-detect top
module retime_debounce_edge
    import retime_debounce_edge_pkg::*;
#(
    parameter int unsigned Width          = 1,
    parameter int unsigned Sync_Stages    = 2,
    parameter int unsigned Debounce_Count = 4
) (
    input  logic             clk,
    input  logic             sres,
    input  logic [Width-1:0] Async_In,
    input  logic [Width-1:0] Event_Clr,
    output logic [Width-1:0] Sync_Out,
    output logic [Width-1:0] Filt_Out,
    output logic [Width-1:0] Rise_Pulse_Out_d,
    output logic [Width-1:0] Fall_Pulse_Out_d,
    output logic [Width-1:0] Trans_Pulse_Out_d,
    output logic [Width-1:0] Event_Sticky
);

    if (Sync_Stages < SYNC_STAGES_MIN || Sync_Stages > SYNC_STAGES_MAX) begin : g_bad_sync_stages
        $error("Sync_Stages out of range 2..8");
    end

    if (Debounce_Count < DEBOUNCE_MIN || Debounce_Count > DEBOUNCE_MAX) begin : g_bad_debounce_count
        $error("Debounce_Count out of range 1..65535");
    end

    if (Width < 1) begin : g_bad_width
        $error("Width must be at least 1");
    end

    for (genvar i = 0; i < Width; i++) begin : g_ch
        retime_debounce_channel #(
            .Sync_Stages    (Sync_Stages),
            .Debounce_Count (Debounce_Count)
        ) u_ch (
            .clk          (clk),
            .sres         (sres),
            .async_in     (Async_In[i]),
            .event_clr    (Event_Clr[i]),
            .sync_out     (Sync_Out[i]),
            .filt_out     (Filt_Out[i]),
            .rise_pulse   (Rise_Pulse_Out_d[i]),
            .fall_pulse   (Fall_Pulse_Out_d[i]),
            .trans_pulse  (Trans_Pulse_Out_d[i]),
            .event_sticky (Event_Sticky[i])
        );
    end

endmodule

// File: tb/tb_retime_debounce_edge.sv
// tb/tb_retime_debounce_edge.sv - directed vector and reference-model bench for retime_debounce_edge
module tb_retime_debounce_edge;

    logic       clk = 1'b0;
    logic       sres;
    logic [3:0] async_in, event_clr;
    logic [3:0] sync_o, filt_o, rise_o, fall_o, trans_o, sticky_o;
    logic [3:0] async2, clr2;
    logic [3:0] sync2, filt2, rise2, fall2, trans2, sticky2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    retime_debounce_edge #(.Width(4), .Sync_Stages(2), .Debounce_Count(3)) dut (
        .clk               (clk),
        .sres              (sres),
        .Async_In          (async_in),
        .Event_Clr         (event_clr),
        .Sync_Out          (sync_o),
        .Filt_Out          (filt_o),
        .Rise_Pulse_Out_d  (rise_o),
        .Fall_Pulse_Out_d  (fall_o),
        .Trans_Pulse_Out_d (trans_o),
        .Event_Sticky      (sticky_o)
    );

    retime_debounce_edge #(.Width(4), .Sync_Stages(3), .Debounce_Count(1)) dut2 (
        .clk               (clk),
        .sres              (sres),
        .Async_In          (async2),
        .Event_Clr         (clr2),
        .Sync_Out          (sync2),
        .Filt_Out          (filt2),
        .Rise_Pulse_Out_d  (rise2),
        .Fall_Pulse_Out_d  (fall2),
        .Trans_Pulse_Out_d (trans2),
        .Event_Sticky      (sticky2)
    );

    typedef struct {
        logic       sres;
        logic [3:0] async_in;
        logic [3:0] sync;
        logic [3:0] filt;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] trans;
        logic [3:0] sticky;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic [3:0] a, input logic [3:0] s,
                                input logic [3:0] f, input logic [3:0] ri, input logic [3:0] fa,
                                input logic [3:0] tr, input logic [3:0] st);
        vec_t v;
        v.sres = r; v.async_in = a; v.sync = s; v.filt = f;
        v.rise = ri; v.fall = fa; v.trans = tr; v.sticky = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sres = 1'b1; async_in = 4'h0; event_clr = 4'h0; async2 = 4'h0; clr2 = 4'h0;
        step();
        sres = 1'b0;
    endtask

    logic [3:0] m_s0, m_s1, m_s2, m_filt, m_fd, m_sticky, m_trans;

    initial begin
        sres = 1'b1; async_in = 4'h0; event_clr = 4'h0; async2 = 4'h0; clr2 = 4'h0;

        // Reset release with all inputs high, then a 2-cycle glitch on channel 0.
        for (int i = 0; i < 5; i++) vecs[i] = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[5]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[6]  = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[7]  = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[8]  = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[9]  = mk(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0);
        vecs[10] = mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
        vecs[11] = mk(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
        vecs[12] = mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[13] = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[14] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[15] = mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[16] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[17] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < 18; i++) begin
            sres = vecs[i].sres;
            async_in = vecs[i].async_in;
            step();
            chk($sformatf("v%0d sync", i),   sync_o,   vecs[i].sync);
            chk($sformatf("v%0d filt", i),   filt_o,   vecs[i].filt);
            chk($sformatf("v%0d rise", i),   rise_o,   vecs[i].rise);
            chk($sformatf("v%0d fall", i),   fall_o,   vecs[i].fall);
            chk($sformatf("v%0d trans", i),  trans_o,  vecs[i].trans);
            chk($sformatf("v%0d sticky", i), sticky_o, vecs[i].sticky);
        end

        // Channel 1: rise, rejected 2-cycle low, then exact 3-cycle threshold fall.
        do_reset();
        async_in = 4'h2;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 2) chk("thr sync", sync_o, 4'h2);
        end
        chk("thr filt pre", filt_o, 4'h0);
        step();
        chk("thr rise filt", filt_o, 4'h2);
        chk("thr rise", rise_o, 4'h2);
        step();
        chk("thr rise end", rise_o, 4'h0);
        chk("thr sticky", sticky_o, 4'h2);
        async_in = 4'h0;
        step(); step();
        async_in = 4'h2;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("glitch filt", filt_o, 4'h2);
            chk("glitch fall", fall_o, 4'h0);
        end
        async_in = 4'h0;
        for (int k = 0; k < 4; k++) step();
        chk("thr hold", filt_o, 4'h2);
        step();
        chk("thr fall filt", filt_o, 4'h0);
        chk("thr fall", fall_o, 4'h2);
        chk("thr trans", trans_o, 4'h2);
        chk("thr fall rise", rise_o, 4'h0);
        step();
        chk("thr fall end", fall_o, 4'h0);
        chk("thr trans end", trans_o, 4'h0);

        // Channel 2: clear coinciding with a transition loses to the set.
        do_reset();
        async_in = 4'h4;
        for (int k = 0; k < 4; k++) step();
        chk("prio filt pre", filt_o, 4'h0);
        step();
        chk("prio trans", trans_o, 4'h4);
        event_clr = 4'h4;
        step();
        chk("prio set wins", sticky_o, 4'h4);
        chk("prio trans end", trans_o, 4'h0);
        step();
        chk("prio cleared", sticky_o, 4'h0);
        event_clr = 4'h0;

        // Channel 3: reset while a fall is two counts in.
        do_reset();
        async_in = 4'h8;
        for (int k = 0; k < 5; k++) step();
        chk("mid filt", filt_o, 4'h8);
        step();
        chk("mid sticky", sticky_o, 4'h8);
        async_in = 4'h0;
        for (int k = 0; k < 4; k++) step();
        chk("mid hold", filt_o, 4'h8);
        sres = 1'b1;
        async_in = 4'h8;
        event_clr = 4'h0;
        step();
        sres = 1'b0;
        chk("mid rst sync", sync_o, 4'h0);
        chk("mid rst filt", filt_o, 4'h0);
        chk("mid rst sticky", sticky_o, 4'h0);
        chk("mid rst trans", trans_o, 4'h0);
        for (int k = 0; k < 4; k++) step();
        chk("mid relaunch pre", filt_o, 4'h0);
        step();
        chk("mid relaunch filt", filt_o, 4'h8);
        chk("mid relaunch rise", rise_o, 4'h8);

        // Sync_Stages=3, Debounce_Count=1: four-edge latency.
        do_reset();
        async2 = 4'hF;
        for (int k = 0; k < 3; k++) step();
        chk("p sync", sync2, 4'hF);
        chk("p filt pre", filt2, 4'h0);
        step();
        chk("p filt", filt2, 4'hF);
        chk("p rise", rise2, 4'hF);
        step();
        chk("p rise end", rise2, 4'h0);
        chk("p sticky", sticky2, 4'hF);

        // Random toggling against a behavioural reference.
        do_reset();
        m_s0 = '0; m_s1 = '0; m_s2 = '0; m_filt = '0; m_fd = '0; m_sticky = '0;
        for (int c = 0; c < 300; c++) begin
            async2 = 4'($urandom);
            clr2   = 4'($urandom) & 4'($urandom);
            m_trans  = m_filt ^ m_fd;
            m_sticky = m_trans | (m_sticky & ~clr2);
            m_fd     = m_filt;
            m_filt   = m_s2;
            m_s2     = m_s1;
            m_s1     = m_s0;
            m_s0     = async2;
            step();
            chk($sformatf("r%0d sync", c),   sync2,   m_s2);
            chk($sformatf("r%0d filt", c),   filt2,   m_filt);
            chk($sformatf("r%0d rise", c),   rise2,   m_filt & ~m_fd);
            chk($sformatf("r%0d fall", c),   fall2,   ~m_filt & m_fd);
            chk($sformatf("r%0d trans", c),  trans2,  m_filt ^ m_fd);
            chk($sformatf("r%0d sticky", c), sticky2, m_sticky);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retime_debounce_edge.md
RETIME_DEBOUNCE_EDGE -- requirements
Module: retime_debounce_edge

Interface
REQ-001 The block SHALL have parameter Width, default 1, giving the number of independent channels.
REQ-002 The block SHALL have parameter Sync_Stages, default 2, giving the synchroniser depth; legal range is 2 to 8.
REQ-003 The block SHALL have parameter Debounce_Count, default 4, giving the consecutive cycles of disagreement needed to accept a new level; legal range is 1 to 65535.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-005 The block SHALL have port sres, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port Async_In, input, Width bits: asynchronous channel inputs.
REQ-007 The block SHALL have port Event_Clr, input, Width bits: per-channel clear for Event_Sticky, synchronous to clk.
REQ-008 The block SHALL have port Sync_Out, output, Width bits: the last synchroniser stage.
REQ-009 The block SHALL have port Filt_Out, output, Width bits: the registered debounced level.
REQ-010 The block SHALL have ports Rise_Pulse_Out_d, Fall_Pulse_Out_d and Trans_Pulse_Out_d, outputs, Width bits each: combinational edge pulses of Filt_Out.
REQ-011 The block SHALL have port Event_Sticky, output, Width bits: latched per-channel transition flags.

Function
REQ-012 Each channel SHALL pass Async_In through a chain of Sync_Stages flops; Sync_Out is the last stage, with latency Sync_Stages edges.
REQ-013 Each channel SHALL hold a counter of width max(1, clog2(Debounce_Count+1)) bits.
REQ-014 Counter when Sync_Out equals Filt_Out: it SHALL clear to 0 at the next edge.
REQ-015 Counter when Sync_Out differs from Filt_Out and the count is below Debounce_Count-1: it SHALL increment at the next edge.
REQ-016 Counter when Sync_Out differs from Filt_Out and the count equals Debounce_Count-1: Filt_Out SHALL take Sync_Out at the next edge and the counter SHALL clear at that same edge.
REQ-017 Filt_Out SHALL therefore change exactly Debounce_Count edges after Sync_Out settles at a new value.
REQ-018 Any Sync_Out disagreement shorter than Debounce_Count cycles SHALL leave Filt_Out unchanged.
REQ-019 A register Filt_Delay SHALL hold the previous-cycle Filt_Out.
REQ-020 Pulse outputs SHALL be combinational from Filt_Out and Filt_Delay:
- Rise_Pulse_Out_d = Filt_Out & ~Filt_Delay
- Fall_Pulse_Out_d = ~Filt_Out & Filt_Delay
- Trans_Pulse_Out_d = Rise_Pulse_Out_d | Fall_Pulse_Out_d
- each pulse lasts exactly one cycle per accepted transition.
REQ-021 Event_Sticky[i] SHALL set at the edge after Trans_Pulse_Out_d[i] is high.
REQ-022 Event_Sticky[i] SHALL clear at the edge where Event_Clr[i] is high and Trans_Pulse_Out_d[i] is low.
REQ-023 When Event_Clr[i] and Trans_Pulse_Out_d[i] are high together, set SHALL win.
REQ-024 Channels SHALL be fully independent; no state is shared between bits.
REQ-025 The counter SHALL never wrap: it saturates by the accept-and-clear rule of REQ-016.

Reset
REQ-026 While sres is high at an edge, these SHALL load 0: synchroniser flops, counters, Filt_Out, Filt_Delay, Event_Sticky.
REQ-027 All pulse outputs SHALL be 0 in the cycle after reset.
REQ-028 Reset SHALL override Event_Clr and any in-progress count.
REQ-029 An input high across reset release SHALL propagate as a normal rise after release, as in REQ-012 and REQ-017.

Structure
REQ-030 A constant function clog2 SHALL reside in the team's shared include and be used for the counter width.
REQ-031 Parameter legality SHALL be checked by elaboration-time assertions kept in the shared include.
REQ-032 The per-channel logic SHALL be one sub-module, retime_debounce_channel, instantiated Width times by a generate loop.
REQ-033 The synchroniser chain MAY reuse Register_Variable_Width, one instance per stage.

Verification
The bench SHALL run these scenarios with Width=4, Sync_Stages=2 and Debounce_Count=3 unless stated otherwise.
REQ-034 Reset release: sres=1 for 5 cycles with Async_In=4'hF -> all outputs 0 during reset; then release ->
- Sync_Out=4'hF after 2 edges
- Filt_Out=4'hF 3 edges later
- Rise_Pulse_Out_d=4'hF for one cycle
- Event_Sticky=4'hF from the next edge.
REQ-035 Glitch rejection: Async_In[0] high for 2 cycles then low -> Sync_Out[0] high for 2 cycles; Filt_Out[0], all pulses and Event_Sticky[0] stay 0.
REQ-036 Exact threshold: Filt_Out[1]=1, then Async_In[1] low for exactly 3 cycles after sync -> Filt_Out[1]=0 on the third edge, Fall_Pulse_Out_d[1] and Trans_Pulse_Out_d[1] high for one cycle. A 2-cycle low -> no change.
REQ-037 Sticky priority: Event_Clr[2]=1 in the same cycle as Trans_Pulse_Out_d[2]=1 -> Event_Sticky[2]=1. Event_Clr[2]=1 one cycle later -> Event_Sticky[2]=0.
REQ-038 Reset mid-debounce: channel 3 counter at 2, then sres=1 for one cycle -> counter, Filt_Out[3] and Event_Sticky[3] are 0. After release with the input still high, Filt_Out[3] rises 2+3 edges later.
REQ-039 Parameter corner: Sync_Stages=3, Debounce_Count=1 -> Filt_Out follows Async_In 4 edges after a change, with one pulse per change; random toggling on 4 channels matches a reference model cycle-exactly.
